// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus shared by the loader and its neighbours.
// The slave side is the loader itself; the master side feeds bytes and observes writes.
interface program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] pm_wr_addr;
    logic [7:0] pm_wr_data;
    logic       pm_wren;

    modport master (
        output in_valid, in_data,
        input  in_ready, pm_wr_addr, pm_wr_data, pm_wren
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, pm_wr_addr, pm_wr_data, pm_wren
    );
endinterface

// File: rtl/program_loader.sv
// Loads a HEADER/LEN/DATA/CHECKSUM frame into program memory and releases the CPU on success.
// Latency: write strobe one cycle after each data byte; backpressure: in_ready low only in DONE or reset.
module program_loader #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    program_loader_if.slave      bus,
    output logic                 cpu_reset,
    output logic                 done,
    output logic                 error,
    output logic [8:0]           load_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t     state;
    logic [7:0] len;
    logic [7:0] len_m1;
    logic [7:0] checksum;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wren;
    logic       accept;
    logic       last_byte;

    assign bus.in_ready   = !sync_reset && (state != DONE);
    assign bus.pm_wr_addr = wr_addr;
    assign bus.pm_wr_data = wr_data;
    assign bus.pm_wren    = wren;

    assign accept    = bus.in_valid && bus.in_ready;
    // A stored length of zero wraps len_m1 to 8'hFF, giving a 256-byte frame.
    assign len_m1    = len - 8'd1;
    assign last_byte = (load_count[7:0] == len_m1);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= IDLE;
            len        <= 8'd0;
            checksum   <= 8'd0;
            wr_addr    <= 8'd0;
            wr_data    <= 8'd0;
            wren       <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            load_count <= 9'd0;
        end else begin
            wren <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (bus.in_data == HEADER) state <= LEN;
                    end
                    LEN: begin
                        len        <= bus.in_data;
                        checksum   <= 8'd0;
                        load_count <= 9'd0;
                        state      <= DATA;
                    end
                    DATA: begin
                        wren       <= 1'b1;
                        wr_addr    <= load_count[7:0];
                        wr_data    <= bus.in_data;
                        checksum   <= checksum + bus.in_data;
                        load_count <= load_count + 9'd1;
                        if (last_byte) state <= CHECK;
                    end
                    CHECK: begin
                        if (bus.in_data == checksum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                    ERROR: begin
                        if (bus.in_data == HEADER) begin
                            state <= LEN;
                            error <= 1'b0;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: expected writes queued on accepted data bytes,
// popped and compared when pm_wren fires; frame status checked after each frame.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       cpu_reset;
    logic       done;
    logic       error;
    logic [8:0] load_count;

    always #5 clk = ~clk;

    program_loader_if bus ();

    program_loader #(.HEADER(8'hA5)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .load_count (load_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    bit          exp_wr_now = 1'b0;
    logic [7:0]  data_buf[256];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle: sample outputs at the falling edge, compare write strobe and scoreboard.
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        check("wr_strobe", 32'(bus.pm_wren), 32'(exp_wr_now));
        if (bus.pm_wren) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.pm_wr_addr), 32'(e[15:8]));
                check("wr_data", 32'(bus.pm_wr_data), 32'(e[7:0]));
            end
        end
        exp_wr_now = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_data, input logic [7:0] addr, input bit rnd);
        bit acc   = 1'b0;
        int tries = 0;
        while (!acc && tries < 200) begin
            tick();
            tries++;
            if (rnd && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = b;
                if (bus.in_ready) begin
                    acc = 1'b1;
                    if (is_data) begin
                        exp_q.push_back({addr, b});
                        exp_wr_now = 1'b1;
                    end
                end
            end
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Header, length and data bytes from data_buf; returns the modulo-256 sum.
    task automatic send_body(input int n, input bit rnd, output logic [7:0] sum);
        logic [7:0] s = 8'd0;
        send_byte(8'hA5, 1'b0, 8'd0, rnd);
        send_byte(8'(n), 1'b0, 8'd0, rnd);
        for (int i = 0; i < n; i++) begin
            send_byte(data_buf[i], 1'b1, 8'(i), rnd);
            s = s + data_buf[i];
        end
        sum = s;
    endtask

    task automatic check_status(input bit e_done, input bit e_err, input bit e_cpu, input int e_cnt);
        idle();
        check("done", 32'(done), 32'(e_done));
        check("error", 32'(error), 32'(e_err));
        check("cpu_reset", 32'(cpu_reset), 32'(e_cpu));
        check("load_count", 32'(load_count), 32'(e_cnt));
        check("in_ready", 32'(bus.in_ready), e_done ? 32'd0 : 32'd1);
    endtask

    task automatic do_reset();
        tick();
        sync_reset   = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_addr", 32'(bus.pm_wr_addr), 32'd0);
        check("rst_data", 32'(bus.pm_wr_data), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_queue_empty", 32'(exp_q.size()), 32'd0);
        sync_reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sum;
        sync_reset   = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        do_reset();

        // Continuous 3-byte frame, good checksum.
        data_buf[0] = 8'h11; data_buf[1] = 8'h22; data_buf[2] = 8'h33;
        send_body(3, 1'b0, sum);
        send_byte(8'h66, 1'b0, 8'd0, 1'b0);
        check_status(1'b1, 1'b0, 1'b0, 3);

        // Bad checksum, then recovery from ERROR with a new frame.
        do_reset();
        data_buf[0] = 8'h10; data_buf[1] = 8'h20;
        send_body(2, 1'b0, sum);
        send_byte(8'h00, 1'b0, 8'd0, 1'b0);
        check_status(1'b0, 1'b1, 1'b1, 2);
        data_buf[0] = 8'h7F;
        send_body(1, 1'b0, sum);
        send_byte(8'h7F, 1'b0, 8'd0, 1'b0);
        check_status(1'b1, 1'b0, 1'b0, 1);

        // Junk in IDLE discarded; HEADER value as data byte.
        do_reset();
        send_byte(8'h00, 1'b0, 8'd0, 1'b0);
        send_byte(8'hFF, 1'b0, 8'd0, 1'b0);
        data_buf[0] = 8'hA5;
        send_body(1, 1'b0, sum);
        send_byte(8'hA5, 1'b0, 8'd0, 1'b0);
        check_status(1'b1, 1'b0, 1'b0, 1);

        // Length byte 0 means 256 data bytes.
        do_reset();
        for (int i = 0; i < 256; i++) data_buf[i] = 8'h01;
        send_body(256, 1'b0, sum);
        check("sum256", 32'(sum), 32'd0);
        send_byte(8'h00, 1'b0, 8'd0, 1'b0);
        check_status(1'b1, 1'b0, 1'b0, 256);

        // Reset mid-frame, then a complete frame loads from address 0.
        do_reset();
        data_buf[0] = 8'h01; data_buf[1] = 8'h02; data_buf[2] = 8'h03; data_buf[3] = 8'h04;
        send_byte(8'hA5, 1'b0, 8'd0, 1'b0);
        send_byte(8'h04, 1'b0, 8'd0, 1'b0);
        send_byte(data_buf[0], 1'b1, 8'd0, 1'b0);
        send_byte(data_buf[1], 1'b1, 8'd1, 1'b0);
        do_reset();
        send_body(4, 1'b0, sum);
        send_byte(8'h0A, 1'b0, 8'd0, 1'b0);
        check_status(1'b1, 1'b0, 1'b0, 4);

        // Same frame continuous and with random in_valid gaps.
        for (int i = 0; i < 8; i++) data_buf[i] = 8'($urandom);
        do_reset();
        send_body(8, 1'b0, sum);
        send_byte(sum, 1'b0, 8'd0, 1'b0);
        check_status(1'b1, 1'b0, 1'b0, 8);
        do_reset();
        send_body(8, 1'b1, sum);
        send_byte(sum, 1'b0, 8'd0, 1'b1);
        check_status(1'b1, 1'b0, 1'b0, 8);
        idle();
        check("done_hold", 32'(done), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
